// File: rtl/corner_editor_pkg.sv
// Shared constants, types and the per-axis delta helper for the corner editor.
// Screen bounds, margins, step sizes and reset positions all live here.
package corner_editor_pkg;

    localparam int H_MAX       = 1023;
    localparam int V_MAX       = 767;
    localparam int MARGIN      = 20;
    localparam int STEP_SLOW   = 1;
    localparam int STEP_FAST   = 8;
    localparam int HOLD_FRAMES = 30;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int HW = 5;

    localparam int X_LO = MARGIN;
    localparam int X_HI = H_MAX - MARGIN;
    localparam int Y_LO = MARGIN;
    localparam int Y_HI = V_MAX - MARGIN;

    localparam logic [1:0] CORNER_TL = 2'd0;
    localparam logic [1:0] CORNER_TR = 2'd1;
    localparam logic [1:0] CORNER_BR = 2'd2;
    localparam logic [1:0] CORNER_BL = 2'd3;

    // Element 3 is the most significant field, matching the {x3,x2,x1,x0} bus order.
    localparam logic [3:0][XW-1:0] X_RESET = {XW'(X_LO), XW'(X_HI), XW'(X_HI), XW'(X_LO)};
    localparam logic [3:0][YW-1:0] Y_RESET = {YW'(Y_HI), YW'(Y_HI), YW'(Y_LO), YW'(Y_LO)};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

    // Signed move on one axis; opposite buttons cancel.
    function automatic logic signed [11:0] axis_delta(input logic neg, input logic pos,
                                                      input logic [HW-1:0] hold);
        logic signed [11:0] step;
        step = (hold >= HW'(HOLD_FRAMES)) ? 12'(STEP_FAST) : 12'(STEP_SLOW);
        if (pos && !neg)
            return step;
        else if (neg && !pos)
            return -step;
        else
            return 12'sd0;
    endfunction

endpackage

// File: rtl/corner_editor_step.sv
// step_clamp: adds a signed delta to a coordinate in 12-bit signed arithmetic
// and saturates the result into [LO, HI]; never wraps.
module step_clamp #(
    parameter int W  = 11,
    parameter int LO = 0,
    parameter int HI = 1023
) (
    input  logic [W-1:0]       cur,
    input  logic signed [11:0] delta,
    output logic [W-1:0]       res
);

    localparam logic signed [11:0] LO_S = 12'(LO);
    localparam logic signed [11:0] HI_S = 12'(HI);

    logic signed [11:0] sum;

    always_comb begin
        sum = $signed(12'(cur)) + delta;
        if (sum < LO_S)
            res = W'(LO);
        else if (sum > HI_S)
            res = W'(HI);
        else
            res = sum[W-1:0];
    end

endmodule

// File: rtl/corner_editor.sv
// Holds the four quadrilateral corners: seeded by the detector load port,
// refined by button nudges once per video frame on the selected corner.
module corner_editor
    import corner_editor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        edit_en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_next,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [43:0] load_x,
    input  logic [39:0] load_y,
    output logic [43:0] corners_x,
    output logic [39:0] corners_y,
    output logic [1:0]  sel,
    output logic        corners_changed,
    output state_e      dbg_state
);

    // Load handshake: a transfer happens on every clock edge where load_valid && load_ready.
    state_e state, state_nx;

    logic [3:0][XW-1:0] cx, lcx;
    logic [3:0][YW-1:0] cy, lcy;
    logic [3:0][XW-1:0] lx;
    logic [3:0][YW-1:0] ly;
    logic [HW-1:0]      hold_cnt;
    logic               vsync_q, btn_next_q;
    logic               tick, next_rise, load_fire, editing, any_dir;
    logic               move_en, move_changed;
    logic signed [11:0] dx, dy;
    logic [XW-1:0]      mvx;
    logic [YW-1:0]      mvy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        if (edit_en)
            state_nx = ST_EDIT;
    end

    assign dbg_state = state;
    assign editing   = (state == ST_EDIT);
    assign tick      = vsync_q & ~vsync;
    assign next_rise = btn_next & ~btn_next_q;
    assign load_fire = load_valid & load_ready;
    assign any_dir   = btn_up | btn_down | btn_left | btn_right;
    assign lx        = load_x;
    assign ly        = load_y;
    assign dx        = axis_delta(btn_left, btn_right, hold_cnt);
    assign dy        = axis_delta(btn_up, btn_down, hold_cnt);

    // One shared clamp per axis for moves, time-shared on the selected corner.
    step_clamp #(.W(XW), .LO(X_LO), .HI(X_HI)) u_move_x (.cur(cx[sel]), .delta(dx), .res(mvx));
    step_clamp #(.W(YW), .LO(Y_LO), .HI(Y_HI)) u_move_y (.cur(cy[sel]), .delta(dy), .res(mvy));

    for (genvar i = 0; i < 4; i++) begin : g_load_clamp
        step_clamp #(.W(XW), .LO(X_LO), .HI(X_HI)) u_load_x (.cur(lx[i]), .delta(12'sd0), .res(lcx[i]));
        step_clamp #(.W(YW), .LO(Y_LO), .HI(Y_HI)) u_load_y (.cur(ly[i]), .delta(12'sd0), .res(lcy[i]));
    end

    // A load on the tick edge drops that frame's move entirely.
    assign move_en      = editing & tick & ~load_fire;
    assign move_changed = move_en & ((mvx != cx[sel]) | (mvy != cy[sel]));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx              <= X_RESET;
            cy              <= Y_RESET;
            sel             <= CORNER_TL;
            hold_cnt        <= '0;
            corners_changed <= 1'b0;
            load_ready      <= 1'b0;
            vsync_q         <= 1'b1;
            btn_next_q      <= 1'b0;
        end else begin
            vsync_q         <= vsync;
            btn_next_q      <= btn_next;
            load_ready      <= 1'b1;
            corners_changed <= load_fire | move_changed;

            if (load_fire) begin
                cx <= lcx;
                cy <= lcy;
            end else if (move_changed) begin
                cx[sel] <= mvx;
                cy[sel] <= mvy;
            end

            // Selection change wins over the tick's hold update; the move itself used the old sel.
            if (!editing) begin
                hold_cnt <= '0;
            end else if (next_rise) begin
                sel      <= sel + 2'd1;
                hold_cnt <= '0;
            end else if (tick && !load_fire) begin
                if (!any_dir)
                    hold_cnt <= '0;
                else if (hold_cnt < HW'(HOLD_FRAMES))
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign corners_x = cx;
    assign corners_y = cy;

endmodule
